hazard_stall_controller: RTL and testbench

- Sequences the control-unit NOP mux and the pipeline front end: PC load-enable, IF/ID load-enable and IF/ID flush.
- Detects load-use hazards between the ID and EX stages.
- Holds the front end for a parameterised number of load cycles and while memory is busy.
- Flushes IF/ID on taken branches, and counts bubble cycles for performance debug.

---
 rtl/hazard_stall_controller_if.sv | 34 +++
 rtl/hazard_stall_controller.sv | 124 ++++++++++++
 tb/tb_hazard_stall_controller.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_controller_if.sv
// Bundle between the decode/execute stages and the hazard stall controller.
// The pipeline side drives the hazard sources; the controller drives the front-end enables.
interface hazard_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       id_rn;
  logic [3:0]       id_rm;
  logic [3:0]       id_rd;
  logic             id_use_rn;
  logic             id_use_rm;
  logic             id_use_rd;
  logic [3:0]       ex_rd;
  logic             ex_rf_enable;
  logic             ex_load;
  logic             branch_taken;
  logic             mem_busy;
  logic             nop_signal;
  logic             pc_le;
  logic             ifid_le;
  logic             ifid_flush;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
    output ex_rd, ex_rf_enable, ex_load, branch_taken, mem_busy,
    input  nop_signal, pc_le, ifid_le, ifid_flush, stall_count
  );

  modport slave (
    input  id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
    input  ex_rd, ex_rf_enable, ex_load, branch_taken, mem_busy,
    output nop_signal, pc_le, ifid_le, ifid_flush, stall_count
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use / memory-busy stall sequencer and IF/ID flush control for the pipeline front end.
// Outputs react in the same cycle a hazard reaches ID; a saturating counter tallies bubbles.
module hazard_stall_controller #(
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  hazard_stall_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LOAD_LATENCY - 1);

  state_t           state_reg, state_next;
  state_t           ret_state_reg, ret_state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [CNT_W-1:0] stall_count_reg, stall_count_next;

  logic [3:0] src_reg [3];
  logic [2:0] src_use;
  logic [2:0] src_hit;
  logic       hazard;
  logic       stall;
  logic       flush;

  assign src_reg[0] = bus.id_rn;
  assign src_reg[1] = bus.id_rm;
  assign src_reg[2] = bus.id_rd;
  assign src_use    = {bus.id_use_rd, bus.id_use_rm, bus.id_use_rn};

  // r15 reads the PC, never a loaded value, so it is excluded operand by operand.
  for (genvar gi = 0; gi < 3; gi++) begin : g_opnd
    assign src_hit[gi] = src_use[gi] && (src_reg[gi] != 4'hF) && (src_reg[gi] == bus.ex_rd);
  end

  assign hazard = bus.ex_load && bus.ex_rf_enable && (|src_hit);

  always_comb begin
    state_next     = state_reg;
    ret_state_next = ret_state_reg;
    cnt_next       = cnt_reg;
    stall          = 1'b0;
    flush          = 1'b0;
    case (state_reg)
      RUN: begin
        if (bus.mem_busy) begin
          stall          = 1'b1;
          ret_state_next = RUN;
          state_next     = MEM_WAIT;
        end else if (hazard) begin
          stall = 1'b1;
          if (LOAD_LATENCY > 1) begin
            cnt_next   = LAT_M1;
            state_next = LOAD_STALL;
          end
        end else if (bus.branch_taken) begin
          flush = 1'b1;
        end
      end
      LOAD_STALL: begin
        // The branch in ID is deliberately ignored; it re-resolves once RUN resumes.
        stall = 1'b1;
        if (bus.mem_busy) begin
          ret_state_next = LOAD_STALL;
          state_next     = MEM_WAIT;
        end else begin
          cnt_next = cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_next = RUN;
          end
        end
      end
      MEM_WAIT: begin
        // The release cycle still bubbles; cnt is untouched so load stalls are not lost.
        stall = 1'b1;
        if (!bus.mem_busy) begin
          state_next = ret_state_reg;
        end
      end
      default: begin
        stall      = 1'b1;
        state_next = RUN;
      end
    endcase
    if (reset) begin
      stall = 1'b1;
      flush = 1'b0;
    end
  end

  always_comb begin
    stall_count_next = stall_count_reg;
    if (stall && (stall_count_reg != {CNT_W{1'b1}})) begin
      stall_count_next = stall_count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= RUN;
      ret_state_reg   <= RUN;
      cnt_reg         <= 4'd0;
      stall_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      ret_state_reg   <= ret_state_next;
      cnt_reg         <= cnt_next;
      stall_count_reg <= stall_count_next;
    end
  end

  assign bus.nop_signal  = stall;
  assign bus.pc_le       = !stall;
  assign bus.ifid_le     = !stall;
  assign bus.ifid_flush  = flush && !stall;
  assign bus.stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: three controller builds share one stimulus stream; a per-build
// cycle model queues expected outputs and a negedge monitor compares them.
module tb_hazard_stall_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] id_rn, id_rm, id_rd, ex_rd;
  logic       id_use_rn, id_use_rm, id_use_rd;
  logic       ex_rf_enable, ex_load, branch_taken, mem_busy;

  hazard_stall_controller_if #(.CNT_W(16)) if_a ();
  hazard_stall_controller_if #(.CNT_W(16)) if_b ();
  hazard_stall_controller_if #(.CNT_W(4))  if_c ();

  assign if_a.id_rn = id_rn;               assign if_b.id_rn = id_rn;               assign if_c.id_rn = id_rn;
  assign if_a.id_rm = id_rm;               assign if_b.id_rm = id_rm;               assign if_c.id_rm = id_rm;
  assign if_a.id_rd = id_rd;               assign if_b.id_rd = id_rd;               assign if_c.id_rd = id_rd;
  assign if_a.id_use_rn = id_use_rn;       assign if_b.id_use_rn = id_use_rn;       assign if_c.id_use_rn = id_use_rn;
  assign if_a.id_use_rm = id_use_rm;       assign if_b.id_use_rm = id_use_rm;       assign if_c.id_use_rm = id_use_rm;
  assign if_a.id_use_rd = id_use_rd;       assign if_b.id_use_rd = id_use_rd;       assign if_c.id_use_rd = id_use_rd;
  assign if_a.ex_rd = ex_rd;               assign if_b.ex_rd = ex_rd;               assign if_c.ex_rd = ex_rd;
  assign if_a.ex_rf_enable = ex_rf_enable; assign if_b.ex_rf_enable = ex_rf_enable; assign if_c.ex_rf_enable = ex_rf_enable;
  assign if_a.ex_load = ex_load;           assign if_b.ex_load = ex_load;           assign if_c.ex_load = ex_load;
  assign if_a.branch_taken = branch_taken; assign if_b.branch_taken = branch_taken; assign if_c.branch_taken = branch_taken;
  assign if_a.mem_busy = mem_busy;         assign if_b.mem_busy = mem_busy;         assign if_c.mem_busy = mem_busy;

  hazard_stall_controller #(.LOAD_LATENCY(1), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  hazard_stall_controller #(.LOAD_LATENCY(3), .CNT_W(16)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
  hazard_stall_controller #(.LOAD_LATENCY(3), .CNT_W(4))  dut_c (.clk(clk), .reset(reset), .bus(if_c));

  logic [3:0]  dut_outs [3];
  logic [15:0] dut_cnt  [3];
  assign dut_outs[0] = {if_a.nop_signal, if_a.pc_le, if_a.ifid_le, if_a.ifid_flush};
  assign dut_outs[1] = {if_b.nop_signal, if_b.pc_le, if_b.ifid_le, if_b.ifid_flush};
  assign dut_outs[2] = {if_c.nop_signal, if_c.pc_le, if_c.ifid_le, if_c.ifid_flush};
  assign dut_cnt[0]  = if_a.stall_count;
  assign dut_cnt[1]  = if_b.stall_count;
  assign dut_cnt[2]  = {12'd0, if_c.stall_count};

  typedef struct {
    int          inst;
    int          cycle;
    logic [3:0]  outs;
    logic [15:0] cnt;
    bit          chk_cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  bit   verbose = 1'b1;

  // Reference model: remaining load-stall budget plus a memory-hold flag per build.
  int lat  [3] = '{1, 3, 3};
  int cmax [3] = '{65535, 65535, 15};
  int load_left [3] = '{0, 0, 0};
  bit mem_hold  [3] = '{1'b0, 1'b0, 1'b0};
  int scount    [3] = '{0, 0, 0};
  bit cnt_known [3] = '{1'b0, 1'b0, 1'b0};

  function automatic bit opnd_hit(input logic use_it, input logic [3:0] r);
    return use_it && (r != 4'hF) && (r == ex_rd);
  endfunction

  task automatic model_cycle();
    bit   hz;
    bit   nop;
    bit   fl;
    exp_t e;
    hz = ex_load && ex_rf_enable &&
         (opnd_hit(id_use_rn, id_rn) || opnd_hit(id_use_rm, id_rm) || opnd_hit(id_use_rd, id_rd));
    for (int k = 0; k < 3; k++) begin
      nop = 1'b0;
      fl  = 1'b0;
      if (reset) begin
        nop = 1'b1;
      end else if (mem_hold[k]) begin
        nop = 1'b1;
        if (!mem_busy) mem_hold[k] = 1'b0;
      end else if (load_left[k] > 0) begin
        nop = 1'b1;
        if (mem_busy) mem_hold[k] = 1'b1;
        else load_left[k] = load_left[k] - 1;
      end else if (mem_busy) begin
        nop = 1'b1;
        mem_hold[k] = 1'b1;
      end else if (hz) begin
        nop = 1'b1;
        load_left[k] = lat[k] - 1;
      end else if (branch_taken) begin
        fl = 1'b1;
      end
      e.inst    = k;
      e.cycle   = cycle;
      e.outs    = {nop, !nop, !nop, fl};
      e.cnt     = 16'(scount[k]);
      e.chk_cnt = cnt_known[k];
      sb.push_back(e);
      if (reset) begin
        load_left[k] = 0;
        mem_hold[k]  = 1'b0;
        scount[k]    = 0;
        cnt_known[k] = 1'b1;
      end else if (nop && scount[k] < cmax[k]) begin
        scount[k] = scount[k] + 1;
      end
    end
  endtask

  // Inputs are set at posedge+1; step records this cycle's expectations and advances.
  task automatic step();
    model_cycle();
    cycle++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ex_load = 1'b0; ex_rf_enable = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0; reset = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_load(input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                          input logic urn, input logic urm);
    ex_load = 1'b1; ex_rf_enable = 1'b1; ex_rd = rd;
    id_rn = rn; id_rm = rm; id_use_rn = urn; id_use_rm = urm; id_use_rd = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (dut_outs[e.inst] !== e.outs) begin
          errors++;
          $display("FAIL ctrl dut%0d cycle %0d: got {nop,pc_le,ifid_le,flush}=%b expected %b",
                   e.inst, e.cycle, dut_outs[e.inst], e.outs);
        end else if (verbose) begin
          $display("cycle %0d dut%0d ctrl=%b cnt=%0d", e.cycle, e.inst, dut_outs[e.inst], dut_cnt[e.inst]);
        end
        if (e.chk_cnt) begin
          checks++;
          if (dut_cnt[e.inst] !== e.cnt) begin
            errors++;
            $display("FAIL stall_count dut%0d cycle %0d: got %0d expected %0d",
                     e.inst, e.cycle, dut_cnt[e.inst], e.cnt);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int r;
    reset = 1'b1;
    id_rn = 4'd0; id_rm = 4'd0; id_rd = 4'd0; ex_rd = 4'd0;
    id_use_rn = 1'b0; id_use_rm = 1'b0; id_use_rd = 1'b0;
    ex_rf_enable = 1'b0; ex_load = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
    @(posedge clk);
    #1;
    step();
    step();
    idle(3);

    // Load-use on Rn, then the r15 exclusion.
    set_load(4'd3, 4'd3, 4'd0, 1'b1, 1'b0); step();
    idle(4);
    set_load(4'd15, 4'd15, 4'd0, 1'b1, 1'b0); step();
    idle(2);

    // Load-use on Rm.
    set_load(4'd5, 4'd0, 4'd5, 1'b0, 1'b1); step();
    idle(4);

    // Load-use with memory busy from the second stall cycle for two cycles.
    set_load(4'd5, 4'd0, 4'd5, 1'b0, 1'b1); step();
    ex_load = 1'b0; mem_busy = 1'b1; step();
    step();
    idle(5);

    // Branch alone, then branch colliding with a hazard.
    branch_taken = 1'b1; step();
    idle(1);
    set_load(4'd7, 4'd0, 4'd7, 1'b0, 1'b1); branch_taken = 1'b1; step();
    idle(4);

    // Persistent hazard long enough to saturate the narrow counter.
    set_load(4'd2, 4'd2, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step();
    idle(3);

    // Reset while the latency-3 builds sit in LOAD_STALL.
    set_load(4'd4, 4'd4, 4'd0, 1'b1, 1'b0); step();
    ex_load = 1'b0; reset = 1'b1; step();
    idle(4);

    verbose = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 6); ex_rd = (r == 6) ? 4'hF : 4'(r);
      r = $urandom_range(0, 6); id_rn = (r == 6) ? 4'hF : 4'(r);
      r = $urandom_range(0, 6); id_rm = (r == 6) ? 4'hF : 4'(r);
      r = $urandom_range(0, 6); id_rd = (r == 6) ? 4'hF : 4'(r);
      id_use_rn    = 1'($urandom_range(0, 1));
      id_use_rm    = 1'($urandom_range(0, 1));
      id_use_rd    = 1'($urandom_range(0, 1));
      ex_load      = 1'($urandom_range(0, 1));
      ex_rf_enable = ($urandom_range(0, 3) != 0);
      branch_taken = ($urandom_range(0, 4) == 0);
      mem_busy     = ($urandom_range(0, 9) == 0);
      reset        = ($urandom_range(0, 99) == 0);
      step();
    end
    idle(2);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
